// File: rtl/moving_sum_decoder_if.sv
// -----------------------------------------------------------------------------
// moving_sum_decoder_if
//
// Purpose:
//   Groups the sample-link signals of moving_sum_decoder into one bundle.
//   The "master" side supplies window sums and the clear strobe and observes
//   the recovered samples. The "slave" side is the decoder.
//
// Signals:
//   clr        master -> slave  synchronous clear of all decoder state
//   sum_in     master -> slave  signed window sum from the averager (SUM_W)
//   sum_valid  master -> slave  sum_in valid this cycle, no backpressure
//   num        slave -> master  recovered signed sample (DATA_W)
//   num_valid  slave -> master  one-cycle pulse per accepted sum
//   err        slave -> master  range error indicator
//   busy_cnt   slave -> master  history write pointer, debug (LOG2_WIN)
// -----------------------------------------------------------------------------
interface moving_sum_decoder_if #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 2,
    parameter int SUM_W    = DATA_W + LOG2_WIN
);
    logic                clr;
    logic [SUM_W-1:0]    sum_in;
    logic                sum_valid;
    logic [DATA_W-1:0]   num;
    logic                num_valid;
    logic                err;
    logic [LOG2_WIN-1:0] busy_cnt;

    modport master (
        output clr,
        output sum_in,
        output sum_valid,
        input  num,
        input  num_valid,
        input  err,
        input  busy_cnt
    );

    modport slave (
        input  clr,
        input  sum_in,
        input  sum_valid,
        output num,
        output num_valid,
        output err,
        output busy_cnt
    );
endinterface

// File: rtl/moving_sum_decoder.sv
// -----------------------------------------------------------------------------
// moving_sum_decoder
//
// Purpose:
//   Inverse of the moving-average datapath. Takes the running window sum S[n]
//   and rebuilds the raw signed sample stream using
//       x[n] = S[n] - S[n-1] + x[n-WIN]
//   with a circular history of the last WIN recovered samples. Reset state is
//   an all-zero window, identical to the averager's, so no priming is needed.
//
// Build option:
//   MOVING_SUM_DEC_SAT_EN  defined   : out-of-range samples saturate, err
//                                      pulses for one cycle, decoding goes on.
//                          undefined : out-of-range sample moves the FSM to
//                                      FAULT, err is sticky until clr/rst.
//
// Ports:
//   clk     system clock, all state on the rising edge
//   rst     asynchronous reset, active high
//   sum_if  moving_sum_decoder_if.slave
//             clr, sum_in, sum_valid            (inputs)
//             num, num_valid, err, busy_cnt     (outputs, all registered)
// -----------------------------------------------------------------------------
module moving_sum_decoder #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 2,
    parameter int SUM_W    = DATA_W + LOG2_WIN
) (
    input  logic                  clk,
    input  logic                  rst,
    moving_sum_decoder_if.slave   sum_if
);

    localparam int WIN = 2 ** LOG2_WIN;
    // Width of the reconstruction sum: difference (SUM_W+1) plus one more
    // bit for adding the oldest sample back in.
    localparam int X_W = SUM_W + 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              r_state;
    logic [SUM_W-1:0]    r_prev_sum;
    logic [DATA_W-1:0]   r_hist [WIN];
    logic [LOG2_WIN-1:0] r_ptr;
    logic [DATA_W-1:0]   r_num;
    logic                r_num_valid;
    logic                r_err;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [SUM_W:0]      w_diff;
    logic [DATA_W-1:0]   w_hist_rd;
    logic [X_W-1:0]      w_x;
    logic                w_in_range;
    logic                w_accept;
    logic [DATA_W-1:0]   w_hist_wdata;
    logic [DATA_W-1:0]   w_num_nxt;
    logic                w_num_valid_nxt;
    logic                w_err_nxt;
`ifdef MOVING_SUM_DEC_SAT_EN
    logic [DATA_W-1:0]   w_sat;
`endif

    // Oldest sample in the window; the slot is overwritten on the same edge,
    // so the value read here is always the pre-write one.
    assign w_hist_rd = r_hist[r_ptr];

    // Sign-extend both operands by one bit so the difference cannot wrap.
    assign w_diff = {sum_if.sum_in[SUM_W-1], sum_if.sum_in}
                  - {r_prev_sum[SUM_W-1], r_prev_sum};

    assign w_x = {w_diff[SUM_W], w_diff}
               + {{(X_W-DATA_W){w_hist_rd[DATA_W-1]}}, w_hist_rd};

    // x fits DATA_W bits signed exactly when every bit from the DATA_W sign
    // position upward is a copy of the sign.
    assign w_in_range = (&w_x[X_W-1:DATA_W-1]) | ~(|w_x[X_W-1:DATA_W-1]);

`ifdef MOVING_SUM_DEC_SAT_EN
    assign w_sat = w_x[X_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
`endif

    // -------------------------------------------------------------------------
    // FSM next state and registered-output next values
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_num_nxt       = r_num;
        w_num_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_accept        = 1'b0;
        w_hist_wdata    = w_x[DATA_W-1:0];

        case (r_state)
            ST_RUN: begin
                if (sum_if.sum_valid) begin
                    if (w_in_range) begin
                        w_num_nxt       = w_x[DATA_W-1:0];
                        w_num_valid_nxt = 1'b1;
                        w_accept        = 1'b1;
                    end else begin
`ifdef MOVING_SUM_DEC_SAT_EN
                        w_hist_wdata    = w_sat;
                        w_num_nxt       = w_sat;
                        w_num_valid_nxt = 1'b1;
                        w_accept        = 1'b1;
                        w_err_nxt       = 1'b1;
`else
                        w_state_nxt     = ST_FAULT;
                        w_err_nxt       = 1'b1;
`endif
                    end
                end
            end
            ST_FAULT: begin
                // Input is ignored; only clr or rst recovers.
                w_err_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else if (sum_if.clr) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers. clr has priority over a coincident sum, which is
    // simply dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_sum  <= '0;
            r_ptr       <= '0;
            r_num       <= '0;
            r_num_valid <= 1'b0;
            r_err       <= 1'b0;
            for (int unsigned i = 0; i < WIN; i++) begin
                r_hist[i] <= '0;
            end
        end else if (sum_if.clr) begin
            r_prev_sum  <= '0;
            r_ptr       <= '0;
            r_num       <= '0;
            r_num_valid <= 1'b0;
            r_err       <= 1'b0;
            for (int unsigned i = 0; i < WIN; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_num       <= w_num_nxt;
            r_num_valid <= w_num_valid_nxt;
            r_err       <= w_err_nxt;
            if (w_accept) begin
                r_hist[r_ptr] <= w_hist_wdata;
                r_ptr         <= r_ptr + LOG2_WIN'(1);
                r_prev_sum    <= sum_if.sum_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sum_if.num       = r_num;
    assign sum_if.num_valid = r_num_valid;
    assign sum_if.err       = r_err;
    assign sum_if.busy_cnt  = r_ptr;

endmodule

// File: tb/tb_moving_sum_decoder.sv
// -----------------------------------------------------------------------------
// tb_moving_sum_decoder
//
// Scoreboard bench for moving_sum_decoder. The driver applies one input
// vector per clock and, from a window-of-samples reference model, pushes the
// expected per-cycle status and any expected recovered sample. A monitor on
// the falling edge pops and compares. Random traffic comes from an averager
// model producing genuine window sums, mixed with gaps, clears and junk sums.
// -----------------------------------------------------------------------------
module tb_moving_sum_decoder;

    localparam int DATA_W   = 8;
    localparam int LOG2_WIN = 2;
    localparam int SUM_W    = DATA_W + LOG2_WIN;
    localparam int WIN      = 2 ** LOG2_WIN;
    localparam int XMAX     = 2 ** (DATA_W - 1) - 1;
    localparam int XMIN     = -(2 ** (DATA_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;

    moving_sum_decoder_if #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN),
        .SUM_W    (SUM_W)
    ) bus ();

    moving_sum_decoder #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN),
        .SUM_W    (SUM_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sum_if (bus)
    );

    always #5 clk = ~clk;

    // Per-cycle expectation: status after the edge.
    typedef struct {
        bit valid;
        bit err;
        int busy;
        int hold_num;
    } cyc_t;

    cyc_t cyc_q[$];
    int   txn_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: last WIN recovered samples, oldest first.
    int m_hist[$];
    int m_prev;
    bit m_fault;
    int m_cnt;
    int m_num;

    // Averager model used to produce realistic sums.
    int a_win[$];
    int a_sum;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < WIN; i++) m_hist.push_back(0);
        m_prev  = 0;
        m_fault = 1'b0;
        m_cnt   = 0;
        m_num   = 0;
    endfunction

    function automatic void avg_reset();
        a_win.delete();
        for (int i = 0; i < WIN; i++) a_win.push_back(0);
        a_sum = 0;
    endfunction

    function automatic void model_accept(input int x, input int s);
        void'(m_hist.pop_front());
        m_hist.push_back(x);
        m_prev = s;
        m_cnt  = (m_cnt + 1) % WIN;
        m_num  = x;
        txn_q.push_back(x);
    endfunction

    // Apply one cycle of stimulus, record expectations, advance past the edge.
    task automatic drive(input bit v, input int s, input bit c);
        cyc_t e;
        int   x;
        bus.sum_valid = v;
        bus.sum_in    = SUM_W'(s);
        bus.clr       = c;
        e.valid = 1'b0;
        e.err   = 1'b0;
        if (c) begin
            model_reset();
        end else if (m_fault) begin
            e.err = 1'b1;
        end else if (v) begin
            x = s - m_prev + m_hist[0];
            if (x >= XMIN && x <= XMAX) begin
                model_accept(x, s);
                e.valid = 1'b1;
            end else begin
`ifdef MOVING_SUM_DEC_SAT_EN
                model_accept((x > XMAX) ? XMAX : XMIN, s);
                e.valid = 1'b1;
                e.err   = 1'b1;
`else
                m_fault = 1'b1;
                e.err   = 1'b1;
`endif
            end
        end
        e.busy     = m_cnt;
        e.hold_num = m_num;
        cyc_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor
    cyc_t mon_e;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (cyc_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underrun: no expectation at t=%0t", $time);
            end else begin
                mon_e = cyc_q.pop_front();
                check("num_valid", int'(bus.num_valid), int'(mon_e.valid));
                check("err", int'(bus.err), int'(mon_e.err));
                check("busy_cnt", int'(bus.busy_cnt), mon_e.busy);
                if (bus.num_valid) begin
                    if (txn_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_sample: num=%0d with empty queue", $signed(bus.num));
                    end else begin
                        check("num", int'($signed(bus.num)), txn_q.pop_front());
                    end
                end else begin
                    check("num_hold", int'($signed(bus.num)), mon_e.hold_num);
                end
            end
        end
    end

    initial begin
        int r;
        int smp;
        bus.clr       = 1'b0;
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
        model_reset();
        avg_reset();

        // Reset values
        #22;
        check("rst_num", int'(bus.num), 0);
        check("rst_num_valid", int'(bus.num_valid), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_busy_cnt", int'(bus.busy_cnt), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic recovery and window wrap: 2,1,-1,0,5
        drive(1, 2, 0);
        drive(1, 3, 0);
        drive(1, 2, 0);
        drive(1, 2, 0);
        drive(1, 5, 0);
        drive(0, 0, 0);

        // Gapped input: 4, then 6 after three idle cycles
        drive(0, 0, 1);
        drive(1, 4, 0);
        drive(0, 99, 0);
        drive(0, 99, 0);
        drive(0, 99, 0);
        drive(1, 10, 0);

        // clr wins over a coincident sum
        drive(1, 7, 1);
        drive(1, 7, 0);

        // Range error handling
        drive(0, 0, 1);
        drive(1, 0, 0);
        drive(1, 200, 0);
        drive(1, 200, 0);
        drive(1, 5, 0);
        drive(0, 0, 0);
        drive(0, 0, 1);
        drive(1, 3, 0);

        // Asynchronous reset mid-stream
        drive(0, 0, 1);
        drive(1, 2, 0);
        drive(1, 3, 0);
        @(negedge clk);
        #1;
        bus.sum_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_num", int'(bus.num), 0);
        check("arst_num_valid", int'(bus.num_valid), 0);
        check("arst_busy_cnt", int'(bus.busy_cnt), 0);
        model_reset();
        txn_q.delete();
        cyc_q.delete();
        #1;
        rst = 1'b0;
        drive(1, 5, 0);

        // Randomized traffic
        drive(0, 0, 1);
        avg_reset();
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                avg_reset();
                drive(bit'($urandom_range(0, 1)), a_sum, 1);
            end else if (r < 5) begin
                drive(1, int'($urandom_range(0, 1023)) - 512, 0);
            end else if (r < 30) begin
                drive(0, int'($urandom_range(0, 1023)) - 512, 0);
            end else begin
                smp   = int'($urandom_range(0, 255)) - 128;
                a_sum = a_sum + smp - a_win.pop_front();
                a_win.push_back(smp);
                drive(1, a_sum, 0);
            end
        end
        drive(0, 0, 0);
        drive(0, 0, 0);
        @(negedge clk);
        #1;
        check("txn_queue_drained", txn_q.size(), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/moving_sum_decoder.md
# moving_sum_decoder

Inverse of the moving-average datapath: accepts the running window sum produced by the moving-average block and reconstructs the original signed 8-bit sample stream. It sits on the receive side of the sample link, after the averager's sum output, and is used for loopback self-check and for recovering raw samples downstream. Recovery uses x[n] = S[n] − S[n−1] + x[n−WIN], with a circular history of the last WIN recovered samples.

## Interface
- DATA_W, 8, sample width (signed two's complement)
- LOG2_WIN, 2, log2 of window length; WIN = 2**LOG2_WIN
- SUM_W, DATA_W+LOG2_WIN, width of incoming window sum (signed)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- clr  input  1  synchronous clear: history, prev sum and state return to reset values
- sum_in  input  SUM_W  signed window sum from averager
- sum_valid  input  1  sum_in valid this cycle (one sum per asserted cycle, no backpressure)
- num  output  DATA_W  recovered signed sample
- num_valid  output  1  num valid, one-cycle pulse per accepted sum
- err  output  1  range error indicator (see Configuration)
- busy_cnt  output  LOG2_WIN  history write pointer (debug)

## Operation
- State: prev_sum (SUM_W), hist[0..WIN−1] (DATA_W each), ptr (LOG2_WIN), FSM {RUN, FAULT}.
- Reset/clr: prev_sum=0, all hist=0, ptr=0, FSM=RUN, num=0, num_valid=0, err=0, busy_cnt=0. Matches averager reset state (all-zero window), so no priming phase.
- RUN, sum_valid=1: diff = sum_in − prev_sum computed at SUM_W+1 bits; x = diff + sign-extended hist[ptr] at SUM_W+2 bits.
  - In range (−2^(DATA_W−1) .. 2^(DATA_W−1)−1): num<=x[DATA_W−1:0], num_valid<=1, hist[ptr]<=x, ptr<=ptr+1 (wraps WIN−1→0), prev_sum<=sum_in.
  - Out of range: behaviour per Configuration.
- RUN, sum_valid=0: num holds last value, num_valid<=0, no state change.
- FAULT: sum_valid ignored, num_valid=0, num holds, err=1; leaves only via clr or rst.
- clr and sum_valid same cycle: clr wins, sample dropped.
- rst mid-stream: immediate asynchronous return to reset values; next sum treated as first after reset.

## Timing
- Latency: num/num_valid registered, valid on the edge after the sum_valid cycle (1 cycle).
- Throughput: one sum per cycle, back-to-back sums supported; hist read and write of same index in one cycle uses old value for x.
- err registered with same latency as num_valid.
- busy_cnt updates on the same edge as num_valid.

## Configuration
- MOVING_SUM_DEC_SAT_EN defined: out-of-range x saturates to +127/−128 (DATA_W=8), num_valid<=1, saturated value written to hist, prev_sum updated, err pulses high one cycle, FSM stays RUN; later outputs are not guaranteed exact.
- Undefined: out-of-range x → FSM<=FAULT, no num_valid, hist/prev_sum/ptr not updated, err sticky high until clr/rst.

## Test plan
- After rst, sums 2,3,2 on consecutive cycles → num 2,1,−1, num_valid pulse each cycle one cycle later, err=0.
- Window wrap (WIN=4): sums 2,3,2,2,5 → num 2,1,−1,0,5; busy_cnt returns to 1 after fifth sample.
- Gapped input: sums 4 and 10 separated by 3 idle cycles → num 4 then 6, num_valid low during gaps, num held at 4.
- Range error: sums 0 then 200 → without macro: no valid, err=1 sticky, subsequent sums ignored until clr; with MOVING_SUM_DEC_SAT_EN: num=127, err one-cycle pulse, next sum 200 → num 0... (x = 0 + hist[2]=0 → 0), err=0.
- clr coincident with sum_valid (sum 7) → no num_valid, all state zero; next sum 7 → num 7.
- Assert rst mid-stream after sums 2,3 → num=0, num_valid=0 asynchronously; next sum 5 → num 5.
